// File: rtl/bus_arbiter4_pkg.sv
// Shared definitions for the 4-requester round-robin bus arbiter:
// requester count, index widths, FSM state encoding and a one-hot helper.
package bus_arbiter4_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;
    localparam int HOLD_W  = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/bus_arbiter4_rr_pick4.sv
// Rotating-priority scan: returns the first set bit of req_mask starting at
// ptr and wrapping modulo 4, plus a flag saying whether any bit was set.
module rr_pick4
    import bus_arbiter4_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_mask,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset back to ptr so the closest match is written last and wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + IDX_W'(k);
            if (req_mask[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter4.sv
// Four-requester round-robin bus arbiter with a bounded hold time: an owner
// that keeps the bus for MAX_HOLD cycles while others wait is preempted.
module bus_arbiter4
    import bus_arbiter4_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   sel,
    output logic               bus_valid,
    output logic               preempt
);

    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]    sel_q, sel_d;
    logic                bus_valid_q, bus_valid_d;
    logic                preempt_q, preempt_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;

    logic [NUM_REQ-1:0]  owner_oh;
    logic                owner_req;
    logic [NUM_REQ-1:0]  scan_mask;
    logic [IDX_W-1:0]    win_idx;
    logic                win_found;
    logic                do_grant;

    assign owner_oh  = idx_to_onehot(sel_q);
    assign owner_req = |(req & owner_oh);
    // While owned, the current owner never competes for its own handover.
    assign scan_mask = (state_q == ST_OWNED) ? (req & ~owner_oh) : req;

    rr_pick4 u_pick (
        .req_mask (scan_mask),
        .ptr      (ptr_q),
        .idx      (win_idx),
        .found    (win_found)
    );

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        bus_valid_d = bus_valid_q;
        preempt_d   = 1'b0;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        do_grant    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    do_grant = 1'b1;
                end
            end
            ST_OWNED: begin
                if (!owner_req) begin
                    if (win_found) begin
                        do_grant = 1'b1;
                    end else begin
                        state_d     = ST_IDLE;
                        gnt_d       = '0;
                        bus_valid_d = 1'b0;
                    end
                end else if (hold_q == HOLD_LIMIT) begin
                    if (win_found) begin
                        do_grant  = 1'b1;
                        preempt_d = 1'b1;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                gnt_d       = '0;
                bus_valid_d = 1'b0;
            end
        endcase

        if (do_grant) begin
            state_d     = ST_OWNED;
            gnt_d       = idx_to_onehot(win_idx);
            sel_d       = win_idx;
            bus_valid_d = 1'b1;
            ptr_d       = win_idx + 1'b1;
            hold_d      = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            sel_q       <= '0;
            bus_valid_q <= 1'b0;
            preempt_q   <= 1'b0;
            ptr_q       <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            bus_valid_q <= bus_valid_d;
            preempt_q   <= preempt_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign bus_valid = bus_valid_q;
    assign preempt   = preempt_q;

endmodule

// File: tb/tb_bus_arbiter4.sv
// Directed bench for bus_arbiter4: reset, single grant, rotation, hold-limit
// preemption, saturation, pointer wrap and asynchronous reset mid-grant.
module tb_bus_arbiter4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       bus_valid;
    logic       preempt;

    int n_checks = 0;
    int n_errors = 0;

    bus_arbiter4 #(.MAX_HOLD(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .sel       (sel),
        .bus_valid (bus_valid),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        req   = 4'b0000;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    function automatic logic [3:0] oh(input int i);
        return 4'b0001 << i;
    endfunction

    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        repeat (2) step();
        check("rst_gnt",   gnt,             4'b0000);
        check("rst_sel",   4'(sel),         4'd0);
        check("rst_valid", 4'(bus_valid),   4'd0);
        check("rst_pre",   4'(preempt),     4'd0);
        check("rst_ptr",   4'(dut.ptr_q),   4'd0);
        rst_n = 1'b1;
        step();
        check("idle_gnt",  gnt,             4'b0000);

        // Single request: one-cycle grant latency, pointer moves past winner.
        req = 4'b0100;
        step();
        check("single_gnt",   gnt,           4'b0100);
        check("single_sel",   4'(sel),       4'd2);
        check("single_valid", 4'(bus_valid), 4'd1);
        check("single_ptr",   4'(dut.ptr_q), 4'd3);
        req = 4'b0000;
        step();
        check("release_gnt",   gnt,           4'b0000);
        check("release_valid", 4'(bus_valid), 4'd0);
        check("release_sel",   4'(sel),       4'd2);

        // All requesting, each owner drops for one edge after 3 cycles.
        reset_dut();
        req = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 3; c++) begin
                check($sformatf("rot_gnt_%0d_%0d", k, c), gnt, oh(order[k]));
                check($sformatf("rot_valid_%0d_%0d", k, c), 4'(bus_valid), 4'd1);
                if (c < 2) step();
            end
            req = 4'b1111 & ~oh(order[k]);
            step();
            req = 4'b1111;
        end

        // Hold limit: owner 1 preempted after its 8th cycle by requester 3.
        reset_dut();
        req = 4'b0010;
        step();
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("hold_gnt_%0d", c), gnt, 4'b0010);
            check($sformatf("hold_pre_%0d", c), 4'(preempt), 4'd0);
            if (c == 2) req = 4'b1010;
            step();
        end
        check("preempt_gnt",   gnt,          4'b1000);
        check("preempt_sel",   4'(sel),      4'd3);
        check("preempt_pulse", 4'(preempt),  4'd1);
        step();
        check("preempt_drop",  4'(preempt),  4'd0);
        check("preempt_keep",  gnt,          4'b1000);

        // Lone requester is never preempted; counter saturates.
        reset_dut();
        req = 4'b0001;
        step();
        for (int c = 0; c < 20; c++) begin
            check($sformatf("solo_gnt_%0d", c), gnt, 4'b0001);
            check($sformatf("solo_pre_%0d", c), 4'(preempt), 4'd0);
            step();
        end
        check("solo_hold_sat", dut.hold_q, 4'd7);

        // Owner 3 releases with ptr=0: requester 0 wins in the same edge.
        reset_dut();
        req = 4'b1000;
        step();
        check("wrap_owner", 4'(sel),       4'd3);
        check("wrap_ptr",   4'(dut.ptr_q), 4'd0);
        req = 4'b1011;
        step();
        check("wrap_hold", gnt, 4'b1000);
        req = 4'b0011;
        step();
        check("wrap_gnt",   gnt,           4'b0001);
        check("wrap_sel",   4'(sel),       4'd0);
        check("wrap_valid", 4'(bus_valid), 4'd1);

        // Asynchronous reset between edges drops the grant immediately.
        #3;
        rst_n = 1'b0;
        #1;
        check("async_gnt",   gnt,           4'b0000);
        check("async_valid", 4'(bus_valid), 4'd0);
        check("async_sel",   4'(sel),       4'd0);
        check("async_pre",   4'(preempt),   4'd0);
        req = 4'b1000;
        #1;
        rst_n = 1'b1;
        step();
        check("post_rst_gnt", gnt,           4'b1000);
        check("post_rst_sel", 4'(sel),       4'd3);
        check("post_rst_ptr", 4'(dut.ptr_q), 4'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
